// File: rtl/paddle_tracker_pkg.sv
// rtl/paddle_tracker_pkg.sv - shared game constants, coordinate type and state encodings
package paddle_tracker_pkg;

  localparam int COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t COL_MIN = 16'd40;
  localparam coord_t COL_MAX = 16'd583;
  localparam coord_t ROW_MAX = 16'd550;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    DROP  = 2'd2,
    GONE  = 2'd3
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/paddle_tracker_if.sv
// rtl/paddle_tracker_if.sv - game-side control inputs and paddle status outputs
interface paddle_tracker_if;
  import paddle_tracker_pkg::*;

  logic       frame;
  logic       frame2;
  logic       padcolce;
  logic       padrowce;
  logic       paddlescore;
  logic       paddlegone;
  logic       btn_left;
  logic       btn_right;
  logic       start;
  coord_t     paddlecol;
  coord_t     paddlerow;
  logic [7:0] score;
  logic       playing;
  logic       lost;

  modport master (
    output frame, frame2, padcolce, padrowce, paddlescore, paddlegone,
           btn_left, btn_right, start,
    input  paddlecol, paddlerow, score, playing, lost
  );

  modport slave (
    input  frame, frame2, padcolce, padrowce, paddlescore, paddlegone,
           btn_left, btn_right, start,
    output paddlecol, paddlerow, score, playing, lost
  );

endinterface

// File: rtl/paddle_tracker_edge_rise.sv
// rtl/paddle_tracker_edge_rise.sv - rising-edge detector on a level input
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/paddle_tracker.sv
// rtl/paddle_tracker.sv - paddle slide/drop state machine with hit scoring
module paddle_tracker
  import paddle_tracker_pkg::*;
#(
  parameter int COL_START = 312,
  parameter int ROW_START = 100
) (
  input logic             clk,
  input logic             reset,
  paddle_tracker_if.slave bus
);

  localparam coord_t COL_INIT = coord_t'(COL_START);
  localparam coord_t ROW_INIT = coord_t'(ROW_START);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  coord_t     col_q, col_d;
  coord_t     row_q, row_d;
  logic [7:0] score_q, score_d;
  logic       playing_q, lost_q;
  logic       score_rise;
  logic       unused_frame2;

  assign unused_frame2 = bus.frame2;

  edge_rise u_score_edge (
    .clk   (clk),
    .reset (reset),
    .d     (bus.paddlescore),
    .rise  (score_rise)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    col_d   = col_q;
    row_d   = row_q;
    score_d = score_q;

    // Scoring uses the registered playing flag so a hit on the DROP->GONE cycle still counts.
    if (score_rise && playing_q && score_q != 8'hFF) score_d = score_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (bus.frame && bus.start) begin
          state_d = SLIDE;
          col_d   = COL_INIT;
          row_d   = ROW_INIT;
          score_d = 8'd0;
          dir_d   = DIR_RIGHT;
        end
      end
      SLIDE: begin
        if (bus.frame && (bus.btn_left ^ bus.btn_right))
          dir_d = bus.btn_left ? DIR_LEFT : DIR_RIGHT;
        // Step with the direction held before this cycle's steering update.
        if (bus.padcolce) begin
          if (dir_q == DIR_RIGHT && col_q < COL_MAX)     col_d = col_q + 16'd1;
          else if (dir_q == DIR_LEFT && col_q > COL_MIN) col_d = col_q - 16'd1;
        end
        if (col_q == COL_MIN || col_q == COL_MAX) state_d = DROP;
      end
      DROP: begin
        if (bus.padrowce && row_q < ROW_MAX) row_d = row_q + 16'd1;
        if (bus.paddlegone) state_d = GONE;
      end
      GONE: begin
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_RIGHT;
      col_q     <= COL_INIT;
      row_q     <= ROW_INIT;
      score_q   <= 8'd0;
      playing_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      col_q     <= col_d;
      row_q     <= row_d;
      score_q   <= score_d;
      playing_q <= (state_d == SLIDE) || (state_d == DROP);
      lost_q    <= (state_d == GONE);
    end
  end

  assign bus.paddlecol = col_q;
  assign bus.paddlerow = row_q;
  assign bus.score     = score_q;
  assign bus.playing   = playing_q;
  assign bus.lost      = lost_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// tb/tb_paddle_tracker.sv - scoreboard bench for paddle_tracker against a behavioural game model
module tb_paddle_tracker;

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic [7:0]  score;
    logic        playing;
    logic        lost;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_cycle = 0;
  snap_t exp_q[$];

  // Model: phase 0 waiting, 1 sliding, 2 dropping, 3 gone; dir is +1 or -1.
  int m_phase, m_col, m_row, m_score, m_dir;
  bit m_prev;

  paddle_tracker_if bus ();

  paddle_tracker #(.COL_START(312), .ROW_START(100)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    snap_t e, g;
    n_cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{bus.paddlecol, bus.paddlerow, bus.score, bus.playing, bus.lost};
      n_total++;
      if (g === e) n_pass++;
      else $display("FAIL cycle%0d: got col=%0d row=%0d score=%0d playing=%b lost=%b expected col=%0d row=%0d score=%0d playing=%b lost=%b",
                    n_cycle, g.col, g.row, g.score, g.playing, g.lost,
                    e.col, e.row, e.score, e.playing, e.lost);
    end
  end

  task automatic model_step();
    int ph = m_phase, c = m_col, r = m_row, s = m_score, d = m_dir;
    snap_t e;
    if (rst) begin
      m_phase = 0; m_col = 312; m_row = 100; m_score = 0; m_dir = 1; m_prev = 0;
    end else begin
      if (bus.paddlescore && !m_prev && (m_phase == 1 || m_phase == 2) && s < 255) s++;
      case (m_phase)
        0: if (bus.frame && bus.start) begin ph = 1; c = 312; r = 100; s = 0; d = 1; end
        1: begin
          if (bus.frame && bus.btn_left != bus.btn_right) d = bus.btn_left ? -1 : 1;
          if (bus.padcolce && m_col + m_dir >= 40 && m_col + m_dir <= 583) c = m_col + m_dir;
          if (m_col == 40 || m_col == 583) ph = 2;
        end
        2: begin
          if (bus.padrowce && m_row < 550) r = m_row + 1;
          if (bus.paddlegone) ph = 3;
        end
        default: if (!bus.start) ph = 0;
      endcase
      m_prev = bus.paddlescore;
      m_phase = ph; m_col = c; m_row = r; m_score = s; m_dir = d;
    end
    e.col = 16'(m_col);
    e.row = 16'(m_row);
    e.score = 8'(m_score);
    e.playing = (m_phase == 1 || m_phase == 2);
    e.lost = (m_phase == 3);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.frame = 0; bus.frame2 = 0; bus.padcolce = 0; bus.padrowce = 0;
    bus.paddlescore = 0; bus.paddlegone = 0; bus.btn_left = 0; bus.btn_right = 0;
    bus.start = 0;
  endtask

  task automatic frame_tick();
    bus.frame = 1; tick(); bus.frame = 0;
  endtask

  task automatic col_steps(input int n);
    bus.padcolce = 1;
    for (int i = 0; i < n; i++) tick();
    bus.padcolce = 0;
  endtask

  task automatic score_edge();
    bus.paddlescore = 1; tick(); bus.paddlescore = 0; tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    clear_inputs();
    @(negedge clk); #1;
    do_reset();
    chk("reset_col", bus.paddlecol, 312);
    chk("reset_row", bus.paddlerow, 100);
    chk("reset_score", bus.score, 0);
    chk("reset_playing", bus.playing, 0);
    chk("reset_lost", bus.lost, 0);

    // Start: needs a frame pulse while start is high.
    bus.start = 1; tick(); tick();
    chk("idle_wait_frame", bus.playing, 0);
    frame_tick();
    chk("start_playing", bus.playing, 1);
    chk("start_col", bus.paddlecol, 312);
    chk("start_row", bus.paddlerow, 100);
    bus.start = 0;

    // Right edge: 271 steps reach 583, then DROP freezes the column.
    bus.btn_right = 1; frame_tick();
    col_steps(271);
    chk("right_edge_col", bus.paddlecol, 583);
    col_steps(3);
    chk("right_edge_hold", bus.paddlecol, 583);
    bus.padcolce = 1; bus.padrowce = 1; tick(); bus.padcolce = 0; bus.padrowce = 0;
    chk("drop_row_step", bus.paddlerow, 101);
    chk("drop_col_frozen", bus.paddlecol, 583);
    bus.btn_right = 0;

    for (int i = 0; i < 5000 && m_row != 548; i++) begin
      bus.padrowce = ($urandom_range(0, 3) != 0); tick();
    end
    bus.padrowce = 0;
    chk("row_548", bus.paddlerow, 548);
    bus.padrowce = 1;
    for (int i = 0; i < 5; i++) tick();
    bus.padrowce = 0;
    chk("row_sat_550", bus.paddlerow, 550);
    bus.paddlegone = 1; tick(); bus.paddlegone = 0;
    chk("gone_lost", bus.lost, 1);
    chk("gone_playing", bus.playing, 0);
    tick();
    chk("idle_after_gone", bus.lost, 0);
    chk("idle_hold_row", bus.paddlerow, 550);

    // Restart, steer to 300 moving right, then conflicting buttons keep direction.
    bus.start = 1; frame_tick(); bus.start = 0;
    bus.btn_left = 1; frame_tick(); bus.btn_left = 0;
    col_steps(17);
    chk("left_295", bus.paddlecol, 295);
    bus.btn_right = 1; frame_tick(); bus.btn_right = 0;
    col_steps(5);
    chk("col_300", bus.paddlecol, 300);
    bus.btn_left = 1; bus.btn_right = 1; frame_tick();
    col_steps(5);
    bus.btn_left = 0; bus.btn_right = 0;
    chk("both_btn_305", bus.paddlecol, 305);

    // Scoring: 3 pulses plus one long hold count 4; saturation at 255.
    for (int i = 0; i < 3; i++) score_edge();
    bus.paddlescore = 1;
    for (int i = 0; i < 10; i++) tick();
    bus.paddlescore = 0; tick(); tick();
    chk("score_4", bus.score, 4);
    for (int i = 0; i < 300; i++) score_edge();
    chk("score_sat_255", bus.score, 255);

    // Random play against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      bus.frame = ($urandom_range(0, 7) == 0);
      bus.frame2 = ($urandom_range(0, 7) == 0);
      bus.padcolce = $urandom_range(0, 1);
      bus.padrowce = $urandom_range(0, 1);
      bus.paddlescore = ($urandom_range(0, 2) == 0);
      bus.paddlegone = ($urandom_range(0, 99) == 0);
      bus.btn_left = ($urandom_range(0, 3) == 0);
      bus.btn_right = ($urandom_range(0, 3) != 0);
      bus.start = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 0; clear_inputs();

    // Reset mid-DROP abandons motion until a new start.
    do_reset();
    bus.start = 1; frame_tick(); bus.start = 0;
    score_edge(); score_edge();
    chk("pre_reset_score", bus.score, 2);
    bus.btn_right = 1; frame_tick(); bus.btn_right = 0;
    bus.padcolce = 1;
    for (int i = 0; i < 2000 && m_phase != 2; i++) tick();
    bus.padcolce = 0;
    bus.padrowce = 1;
    for (int i = 0; i < 2000 && m_row != 400; i++) tick();
    bus.padrowce = 0;
    chk("pre_reset_row", bus.paddlerow, 400);
    rst = 1; #1;
    chk("async_rst_playing", bus.playing, 0);
    chk("async_rst_row", bus.paddlerow, 100);
    chk("async_rst_col", bus.paddlecol, 312);
    chk("async_rst_score", bus.score, 0);
    tick(); rst = 0;
    bus.padcolce = 1; bus.padrowce = 1; bus.btn_right = 1;
    for (int i = 0; i < 10; i++) tick();
    clear_inputs();
    chk("post_rst_col", bus.paddlecol, 312);
    chk("post_rst_row", bus.paddlerow, 100);
    chk("post_rst_playing", bus.playing, 0);

    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/paddle_tracker.md
PADDLE_TRACKER -- requirements
Module: paddle_tracker

Interface
REQ-001 SHALL have parameter COL_START, default 312, paddle column loaded on reset and on restart.
REQ-002 SHALL have parameter ROW_START, default 100, paddle row loaded on reset and on restart.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame  input  1  one-cycle pulse per video frame.
REQ-006 SHALL have port frame2  input  1  one-cycle pulse, second drop tick per frame.
REQ-007 SHALL have port padcolce  input  1  column-step enable from the paddle renderer.
REQ-008 SHALL have port padrowce  input  1  row-step enable from the paddle renderer.
REQ-009 SHALL have port paddlescore  input  1  level, ball touching paddle scoring edge.
REQ-010 SHALL have port paddlegone  input  1  level, paddle below visible limit.
REQ-011 SHALL have port btn_left  input  1  synchronous player button, move left.
REQ-012 SHALL have port btn_right  input  1  synchronous player button, move right.
REQ-013 SHALL have port start  input  1  level, begin or restart play.
REQ-014 SHALL have port paddlecol  output  16  current paddle column.
REQ-015 SHALL have port paddlerow  output  16  current paddle bottom row.
REQ-016 SHALL have port score  output  8  paddle hit count.
REQ-017 SHALL have port playing  output  1  high in SLIDE or DROP.
REQ-018 SHALL have port lost  output  1  high in GONE.

Function
REQ-019 SHALL implement FSM states IDLE, SLIDE, DROP, GONE.
REQ-020 IDLE->SLIDE SHALL occur on the first frame pulse with start=1; col, row, score and dir SHALL reload to COL_START, ROW_START, 0, right on that transition.
REQ-021 In SLIDE, dir SHALL update only on frame pulses: btn_left alone -> left, btn_right alone -> right, both or neither -> dir unchanged.
REQ-022 In SLIDE, each cycle with padcolce=1 SHALL step paddlecol by 1 in dir (left -1, right +1), using the dir value held before that cycle's update.
REQ-023 paddlecol SHALL clamp to 40..583; a step that would leave that range SHALL leave paddlecol unchanged.
REQ-024 SLIDE->DROP SHALL occur in the cycle after paddlecol equals 40 or 583.
REQ-025 In DROP, each cycle with padrowce=1 SHALL increment paddlerow by 1, saturating at 550; padcolce SHALL be ignored in DROP and steering SHALL be frozen.
REQ-026 DROP->GONE SHALL occur in the cycle after paddlegone=1; GONE SHALL hold paddlecol and paddlerow.
REQ-027 GONE->IDLE SHALL occur when start=0; IDLE SHALL hold all positions and score.
REQ-028 score SHALL increment by 1 on each 0->1 edge of paddlescore while playing=1, saturating at 255; the edge detector SHALL be registered, giving one-cycle latency.
REQ-029 paddlescore held high SHALL count once; an edge in the same cycle as an FSM transition out of DROP SHALL still count.
REQ-030 padcolce and padrowce both high in one cycle SHALL act only on the enable belonging to the current state.
REQ-031 playing and lost SHALL be registered decodes of the state, valid the same cycle as the state.

Reset
REQ-032 reset SHALL immediately force state=IDLE, paddlecol=COL_START, paddlerow=ROW_START, score=0, dir=right, edge register=0, playing=0, lost=0.
REQ-033 reset asserted mid-SLIDE or mid-DROP SHALL abandon motion with no further steps after deassertion until a new start.

Structure
REQ-034 The state encoding, column limits 40 and 583, row ceiling 550, and 16-bit coordinate width SHALL live in the shared game package.
REQ-035 The paddlescore rising-edge detector SHALL be a sub-module named edge_rise.

Verification
REQ-036 Reset, start=1, frame pulse -> state SLIDE, col=312, row=100, score=0, playing=1.
REQ-037 SLIDE, btn_right held, 271 padcolce pulses -> col=583, DROP next cycle, further padcolce leaves col=583.
REQ-038 SLIDE at col=300, btn_left and btn_right both held across a frame pulse, 5 padcolce pulses -> col=305.
REQ-039 DROP at row=548, 5 padrowce pulses -> row=550; paddlegone=1 -> GONE next cycle, lost=1.
REQ-040 paddlescore pulsed 3 times and held high 10 cycles once during SLIDE -> score=4; 300 edges -> score=255.
REQ-041 Assert reset mid-DROP at row=400 -> immediate IDLE, row=100, col=312, score=0.
